// File: rtl/k580_pkg.sv
// Shared types and constants for the K580WT57 (8257-style) DMA controller.
package k580_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        St1,
        St2,
        St3
    } dma_state_e;

    typedef enum logic [1:0] {
        XferVerify = 2'b00,
        XferWrite  = 2'b01,
        XferRead   = 2'b10,
        XferBad    = 2'b11
    } xfer_e;

    localparam int unsigned MaxChannels = 4;
    localparam logic [3:0]  RegChanLast = 4'd7;
    localparam logic [3:0]  RegMode     = 4'd8;

    localparam int unsigned ModeRotBit    = 4;
    localparam int unsigned ModeExtWrBit  = 5;
    localparam int unsigned ModeTcStopBit = 6;
    localparam int unsigned ModeAutoBit   = 7;

    // Returns {found, index}. With rot set, the channel after 'last' has top priority.
    function automatic logic [2:0] pick_chan(input logic [3:0] act, input logic [1:0] last,
                                             input logic rot);
        logic [1:0] idx;
        pick_chan = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = rot ? (last + 2'(i) + 2'd1) : 2'(i);
            if (act[idx]) pick_chan = {1'b1, idx};
        end
    endfunction

endpackage

// File: rtl/k580wt57_if.sv
// CPU, device and memory-bus signals of the K580WT57 DMA controller.
interface k580wt57_if;
    logic        ce;
    logic [3:0]  iaddr;
    logic [7:0]  idata;
    logic        iwe_n;
    logic        ird_n;
    logic [7:0]  odata;
    logic [3:0]  drq;
    logic [3:0]  dack;
    logic        hrq;
    logic        hlda;
    logic [15:0] oaddr;
    logic        omemr_n;
    logic        omemw_n;
    logic        tc;

    modport slave (
        input  ce, iaddr, idata, iwe_n, ird_n, drq, hlda,
        output odata, dack, hrq, oaddr, omemr_n, omemw_n, tc
    );

    modport master (
        output ce, iaddr, idata, iwe_n, ird_n, drq, hlda,
        input  odata, dack, hrq, oaddr, omemr_n, omemw_n, tc
    );
endinterface

// File: rtl/dma_channel.sv
// One DMA channel: 16-bit address, 14-bit count and transfer mode, with byte-wise CPU loads,
// per-transfer step and whole-channel reload.
module dma_channel
    import k580_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_i,
    input  logic        wr_hi_i,
    input  logic        wr_cnt_i,
    input  logic [7:0]  wdata_i,
    input  logic        step_i,
    input  logic        load_i,
    input  logic [15:0] load_addr_i,
    input  logic [13:0] load_cnt_i,
    input  xfer_e       load_mode_i,
    output logic [15:0] addr_o,
    output logic [13:0] cnt_o,
    output xfer_e       mode_o,
    output logic        zero_o
);
    logic [15:0] addr_q, addr_d;
    logic [13:0] cnt_q, cnt_d;
    xfer_e       mode_q, mode_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            mode_q <= XferVerify;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load_i) begin
            addr_d = load_addr_i;
            cnt_d  = load_cnt_i;
            mode_d = load_mode_i;
        end else if (step_i) begin
            addr_d = addr_q + 16'd1;
            cnt_d  = cnt_q - 14'd1;
        end else if (wr_i) begin
            if (!wr_cnt_i) begin
                if (wr_hi_i) addr_d[15:8] = wdata_i;
                else         addr_d[7:0]  = wdata_i;
            end else begin
                // Top two bits of the count high byte carry the transfer type.
                if (wr_hi_i) begin
                    cnt_d[13:8] = wdata_i[5:0];
                    mode_d      = xfer_e'(wdata_i[7:6]);
                end else begin
                    cnt_d[7:0] = wdata_i;
                end
            end
        end
    end

    assign addr_o = addr_q;
    assign cnt_o  = cnt_q;
    assign mode_o = mode_q;
    assign zero_o = (cnt_q == 14'd0);

endmodule

// File: rtl/k580wt57.sv
// K580WT57 DMA controller top: CPU register file, arbitration and IDLE/HOLD/S1/S2/S3 sequencer.
// Channel-2 autoload from channel 3 is built only when DMA_AUTOLOAD_EN is defined.
module k580wt57
    import k580_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input logic       clk,
    input logic       reset,
    k580wt57_if.slave bus
);
    localparam logic [3:0] ChanMask = 4'((1 << NCH) - 1);

    logic        iwe_q, ird_q;
    logic        wr_evt, rd_evt;
    logic        pend_q, pend_d;
    logic [3:0]  pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        apply;
    logic [3:0]  apply_addr;
    logic [7:0]  apply_data;
    logic [7:0]  mode_q, mode_d;
    logic        ff_q, ff_d;
    logic [3:0]  tcs_q, tcs_d;
    logic        update_q, update_d;
    dma_state_e  state_q, state_d;
    logic [1:0]  chan_q, chan_d;
    logic [1:0]  last_q, last_d;
    logic        busy, step, tc_hit, autoload;
    logic [3:0]  active;
    logic [2:0]  pick;
    logic [3:0]  ch_wr;
    logic [15:0] ch_addr [MaxChannels];
    logic [13:0] ch_cnt  [MaxChannels];
    xfer_e       ch_mode [MaxChannels];
    logic [3:0]  ch_zero;
    xfer_e       cur_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iwe_q       <= 1'b1;
            ird_q       <= 1'b1;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            mode_q      <= '0;
            ff_q        <= 1'b0;
            tcs_q       <= '0;
            update_q    <= 1'b0;
            state_q     <= StIdle;
            chan_q      <= '0;
            last_q      <= 2'(NCH - 1);
        end else begin
            iwe_q       <= bus.iwe_n;
            ird_q       <= bus.ird_n;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            mode_q      <= mode_d;
            ff_q        <= ff_d;
            tcs_q       <= tcs_d;
            update_q    <= update_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            last_q      <= last_d;
        end
    end

    assign wr_evt = !iwe_q && bus.iwe_n;
    assign rd_evt = !ird_q && bus.ird_n;
    assign busy   = (state_q == St1) || (state_q == St2) || (state_q == St3);
    assign active = mode_q[3:0] & bus.drq & ChanMask;
    assign pick   = pick_chan(active, last_q, mode_q[ModeRotBit]);

    // Writes arriving during S1..S3 are parked and applied once the cycle is over.
    // A second write inside the same cycle replaces the parked one.
    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        apply       = 1'b0;
        apply_addr  = pend_addr_q;
        apply_data  = pend_data_q;
        if (!busy && pend_q) begin
            apply  = 1'b1;
            pend_d = 1'b0;
        end else if (!busy && wr_evt) begin
            apply      = 1'b1;
            apply_addr = bus.iaddr;
            apply_data = bus.idata;
        end
        if (wr_evt && (busy || pend_q)) begin
            pend_d      = 1'b1;
            pend_addr_d = bus.iaddr;
            pend_data_d = bus.idata;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        last_d  = last_q;
        step    = 1'b0;
        if (bus.ce) begin
            unique case (state_q)
                StIdle: if (|active) state_d = StHold;
                StHold: begin
                    if (!pick[2]) begin
                        state_d = StIdle;
                    end else if (bus.hlda) begin
                        state_d = St1;
                        chan_d  = pick[1:0];
                        last_d  = pick[1:0];
                    end
                end
                St1: state_d = bus.hlda ? St2 : StIdle;
                St2: state_d = bus.hlda ? St3 : StIdle;
                St3: begin
                    if (!bus.hlda) begin
                        state_d = StIdle;
                    end else begin
                        step    = 1'b1;
                        state_d = bus.drq[chan_q] ? StHold : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign tc_hit = step && ch_zero[chan_q];

`ifdef DMA_AUTOLOAD_EN
    assign autoload = tc_hit && (NCH > 3) && (chan_q == 2'd2) && mode_q[ModeAutoBit];
`else
    logic unused_auto_bit;
    assign unused_auto_bit = mode_q[ModeAutoBit];
    assign autoload        = 1'b0;
`endif

    always_comb begin
        mode_d   = mode_q;
        ff_d     = ff_q;
        tcs_d    = tcs_q;
        update_d = update_q;
        ch_wr    = '0;
        if (rd_evt && bus.iaddr == RegMode) begin
            tcs_d    = '0;
            update_d = 1'b0;
        end
        if (apply) begin
            if (apply_addr == RegMode) begin
                mode_d = apply_data;
                ff_d   = 1'b0;
            end else if (apply_addr <= RegChanLast && 32'(apply_addr[2:1]) < NCH) begin
                ch_wr[apply_addr[2:1]] = 1'b1;
                ff_d                   = !ff_q;
            end
        end
        if (tc_hit && mode_q[ModeTcStopBit]) begin
            tcs_d[chan_q] = 1'b1;
            if (!autoload) mode_d[chan_q] = 1'b0;
        end
        if (autoload) update_d = 1'b1;
    end

    for (genvar n = 0; n < MaxChannels; n++) begin : g_ch
        if (n < NCH) begin : g_on
            dma_channel u_ch (
                .clk         (clk),
                .reset       (reset),
                .wr_i        (ch_wr[n]),
                .wr_hi_i     (ff_q),
                .wr_cnt_i    (apply_addr[0]),
                .wdata_i     (apply_data),
                .step_i      (step && (chan_q == 2'(n))),
                .load_i      (autoload && (n == 2)),
                .load_addr_i (ch_addr[MaxChannels-1]),
                .load_cnt_i  (ch_cnt[MaxChannels-1]),
                .load_mode_i (ch_mode[MaxChannels-1]),
                .addr_o      (ch_addr[n]),
                .cnt_o       (ch_cnt[n]),
                .mode_o      (ch_mode[n]),
                .zero_o      (ch_zero[n])
            );
        end else begin : g_off
            assign ch_addr[n] = '0;
            assign ch_cnt[n]  = '0;
            assign ch_mode[n] = XferVerify;
            assign ch_zero[n] = 1'b0;
        end
    end

    assign cur_mode = ch_mode[chan_q];

    always_comb begin
        bus.hrq     = (state_q != StIdle);
        bus.dack    = '0;
        bus.oaddr   = '0;
        bus.tc      = 1'b0;
        bus.omemr_n = 1'b1;
        bus.omemw_n = 1'b1;
        if (busy) begin
            bus.dack[chan_q] = 1'b1;
            bus.oaddr        = ch_addr[chan_q];
            bus.tc           = ch_zero[chan_q];
        end
        if (state_q == St2 && cur_mode == XferRead) bus.omemr_n = 1'b0;
        if (cur_mode == XferWrite &&
            (state_q == St2 || (state_q == St1 && mode_q[ModeExtWrBit]))) begin
            bus.omemw_n = 1'b0;
        end
        bus.odata = (bus.iaddr == RegMode) ? {3'b000, update_q, tcs_q} : 8'h00;
    end

endmodule

// File: doc/k580wt57.md
K580WT57 -- requirements
Module: k580wt57

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  system clock; all state changes on rising edge
  reset  in  1  asynchronous, active-high reset
  ce  in  1  DMA clock enable; state machine advances only when ce=1
  iaddr  in  4  CPU register address
  idata  in  8  CPU write data
  iwe_n  in  1  CPU write strobe, active low; acted on at rising edge
  ird_n  in  1  CPU read strobe, active low
  odata  out  8  CPU read data
  drq  in  4  per-channel DMA requests from devices, e.g. CRT controller
  dack  out  4  per-channel acknowledge, one-hot or zero
  hrq  out  1  bus hold request to CPU
  hlda  in  1  bus hold acknowledge
  oaddr  out  16  memory address during transfer
  omemr_n  out  1  memory read strobe, active low
  omemw_n  out  1  memory write strobe, active low
  tc  out  1  terminal count, valid with the last transfer's dack
REQ-002 SHALL have these parameters, one per line: name, default, meaning.
  NCH, 4, number of channels (1..4)

Function
REQ-003 SHALL hold per channel a 16-bit address, a 14-bit count, and a 2-bit mode: 10=mem read, 01=mem write, 00=verify.
REQ-004 SHALL map iaddr 2n/2n+1 (n<NCH) to channel n address/count, 8=mode register (write) and status (read), 9..15 ignored.
REQ-005 SHALL load address/count byte-wise through one shared first/last flip-flop: low byte first, then high byte; count high byte bits [7:6] are the mode; a mode-register write clears the flip-flop.
REQ-006 SHALL define mode register bits as [3:0] channel enable, 4 rotating priority, 5 extended write, 6 TC-stop, 7 autoload.
REQ-007 SHALL return status {3'b0,update,tc[3:0]} on odata; the ird_n rising edge at iaddr=8 clears tc[3:0].
REQ-008 SHALL run states IDLE, HOLD, S1, S2, S3; transitions occur only on ce=1 edges.
REQ-009 SHALL go IDLE->HOLD and assert hrq when any enabled channel has drq=1; it SHALL wait in HOLD until hlda=1.
REQ-010 SHALL, in HOLD with hlda=1, select the highest-priority active channel: fixed order 0 highest, or rotating so the last-serviced channel becomes lowest.
REQ-011 SHALL, in S1, drive oaddr=channel address and dack[n]=1.
REQ-012 SHALL, in S2, drive omemr_n=0 (mode 10) or omemw_n=0 (mode 01); with extended write, omemw_n SHALL already be 0 in S1.
REQ-013 SHALL, in S3, release strobes, increment the address (wrap FFFF->0000) and decrement the count; tc=1 SHALL assert when the count was 0 before the decrement (N+1 bytes total).
REQ-014 SHALL, after S3, return to HOLD if drq[n] is still 1, else to IDLE with hrq=0 and dack=0.
REQ-015 SHALL, on TC with TC-stop set, clear that channel's enable bit and set its status tc bit.
REQ-016 SHALL make a drq drop mid-cycle complete the current byte; a CPU register write during S1-S3 SHALL take effect after S3.
REQ-017 SHALL make hlda=0 in S1-S3 abort to IDLE with strobes released and counters unchanged.

Reset
REQ-018 SHALL, on reset, drive hrq=0, dack=0, omemr_n=1, omemw_n=1, tc=0, oaddr=0, odata status 0 and state IDLE, and clear the mode register, flip-flop and all channel registers, regardless of ce.

Configuration
REQ-019 SHALL, with DMA_AUTOLOAD_EN defined, on channel 2 TC with mode bit 7 set, reload channel 2 address/count/mode from channel 3 and pulse update=1 until the next status read; channel 2 SHALL stay enabled.
REQ-020 SHALL, without DMA_AUTOLOAD_EN, ignore mode bit 7 and read update as 0.

Structure
REQ-021 SHALL keep state encoding, register-index constants and mode bit positions in a shared package, k580_pkg.
REQ-022 SHALL implement the per-channel address/count/mode registers plus increment/decrement as sub-module dma_channel, instantiated NCH times.

Verification
REQ-023 Ch2 addr=0x7600, count=0x8003 (read, 4 bytes), enable=0x04, drq[2] held -> four cycles, oaddr 7600..7603, omemr_n low each S2, tc=1 on the 4th only.
REQ-024 drq[0] and drq[2] simultaneous, fixed priority -> ch0 serviced first; rotating -> the order alternates each byte.
REQ-025 Autoload on: ch3 addr=0x7600, count=0x8001, mode=0x84, run ch2 to TC -> ch2 reloads to 0x7600/1, update=1, 3rd transfer at 0x7600.
REQ-026 TC-stop set, count=0 -> single transfer, tc=1, enable bit cleared, status=0x01 for ch0; status read then returns 0x00.
REQ-027 hlda held 0 -> hrq=1 persists, no dack; reset asserted in S2 -> strobes go to 1 immediately.
